// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Receive-side handshake bundle between the UART receiver and its consumer.
//   master : the receiver; drives the byte, valid and error flags, reads the ack
//   slave  : the consumer; reads the byte and flags, drives the ack
//   Signals:
//     rx_valid  byte available in rx_data, held until accepted
//     rx_data   received byte, stable while rx_valid=1
//     rx_ack    consumer accepts the byte (only meaningful with rx_valid=1)
//     overrun   sticky, a byte completed while the previous one was unaccepted
//     frame_err one-cycle pulse when a stop bit is sampled low
`timescale 1ns/1ps
interface uart_receiver_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rx_valid,
    output rx_data,
    output overrun,
    output frame_err,
    input  rx_ack
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  overrun,
    input  frame_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receive front end, LSB first, WAIT clock cycles per bit.
//   Synchronises the raw line, validates the start bit at half-bit, samples
//   each data bit mid-bit and holds the byte in a one-entry valid/ack buffer.
//   Ports:
//     clk     system clock, rising edge
//     reset   asynchronous reset, active low
//     uart_rx raw serial line, idle high, asynchronous to clk
//     rx_bus  handshake bundle (master side): rx_valid, rx_data, rx_ack,
//             overrun, frame_err
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle, waiting for a low level on the synchronised line
//   S_START | counting to half a bit to confirm the start bit
//   S_DATA  | sampling 8 data bits, one per WAIT cycles
//   S_STOP  | sampling the stop bit; deliver byte or flag framing error
//   S_BREAK | stop bit was low; wait for the line to return high
`timescale 1ns/1ps
module uart_receiver #(
  parameter int WAIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            uart_rx,
  uart_receiver_if.master rx_bus
);

  localparam int CW = $clog2(WAIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(WAIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        sync1_q, sync2_q;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_s;
  logic        deliver;
  logic        ack_take;

  // Two-flop synchroniser; flops reset high so reset never looks like a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before half a bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            // Re-arm at mid-stop-bit; the rest of the stop bit is idle-high.
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One-entry buffer. An ack in the delivery cycle frees the slot in time
  // for the new byte, so that case is neither a drop nor an overrun.
  assign ack_take = rx_bus.rx_ack & rx_valid_q;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    overrun_d  = overrun_q;

    if (ack_take) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (deliver) begin
      if (!rx_valid_q || ack_take) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_bus.rx_valid  = rx_valid_q;
  assign rx_bus.rx_data   = rx_data_q;
  assign rx_bus.overrun   = overrun_q;
  assign rx_bus.frame_err = frame_err_q;

endmodule
